// File: rtl/muldiv_seq.sv
// RV32M iterative multiply/divide: XLEN+2 cycle latency (1 for divide-by-zero/overflow).
// No backpressure on the result; stall holds the pipeline front from acceptance until DONE.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [2:0]        op;
  logic              neg_res;
  logic              neg_rem;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;

  logic              is_div, s1_signed, s2_signed, rs1_neg, rs2_neg;
  logic [XLEN-1:0]   rs1_abs, rs2_abs, min_val, special_res;
  logic              div_zero, div_ovf;

  always_comb begin
    is_div    = func3[2];
    s1_signed = func3[2] ? ~func3[0] : (func3[1:0] != 2'b11);
    s2_signed = func3[2] ? ~func3[0] : ~func3[1];
    rs1_neg   = s1_signed & rs1[XLEN-1];
    rs2_neg   = s2_signed & rs2[XLEN-1];
    rs1_abs   = rs1_neg ? -rs1 : rs1;
    rs2_abs   = rs2_neg ? -rs2 : rs2;
    min_val   = {1'b1, {(XLEN-1){1'b0}}};
    div_zero  = is_div & (rs2 == '0);
    div_ovf   = is_div & ~func3[0] & (rs1 == min_val) & (&rs2);
    // REM/REMU by zero hand back the dividend; signed overflow leaves no remainder
    if (div_zero)
      special_res = func3[1] ? rs1 : '1;
    else
      special_res = func3[1] ? '0 : rs1;
  end

  // Multiply step: conditional add into the upper half, then shift the pair right
  logic [XLEN:0]     mul_sum, mul_hi;
  logic [2*XLEN-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    mul_hi   = acc[0] ? mul_sum : {1'b0, acc[2*XLEN-1:XLEN]};
    mul_next = {mul_hi, acc[XLEN-1:1]};
  end

  // Divide step: the shifted partial remainder needs XLEN+1 bits, plus one for the borrow
  logic [XLEN:0]     part_rem;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    part_rem = acc[2*XLEN-1:XLEN-1];
    diff     = {1'b0, part_rem} - {2'b00, opnd};
    if (diff[XLEN+1])
      div_next = {part_rem[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quot_fix = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (op[2])
      fix_res = op[1] ? rem_fix : quot_fix;
    else
      fix_res = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op      <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      result  <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op      <= func3;
            neg_res <= rs1_neg ^ rs2_neg;
            neg_rem <= rs1_neg;
            cnt     <= CW'(XLEN - 1);
            if (is_div) begin
              opnd <= rs2_abs;
              acc  <= {{XLEN{1'b0}}, rs1_abs};
            end else begin
              opnd <= rs1_abs;
              acc  <= {{XLEN{1'b0}}, rs2_abs};
            end
            if (div_zero | div_ovf) begin
              result <= special_res;
              valid  <= 1'b1;
              state  <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= op[2] ? div_next : mul_next;
          if (cnt == '0)
            state <= FIX;
          else
            cnt <= cnt - CW'(1);
        end
        FIX: begin
          result <= fix_res;
          busy   <= 1'b0;
          valid  <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = (start & (state == IDLE)) | busy;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed checks of muldiv_seq against a plain-arithmetic RV32M model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic        stall;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] MIN = 32'h8000_0000;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3), .rs1(rs1), .rs2(rs2),
    .busy(busy), .valid(valid), .result(result), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] pu;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == MIN && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return MIN;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op and follows it to its valid pulse; optionally re-pulses start at cycle inject_cyc
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int inject_cyc, output logic [31:0] res, output int lat,
                        output int bcnt, output int stall_bad, output bit got);
    got = 1'b0; lat = 0; bcnt = 0; stall_bad = 0; res = '0;
    @(negedge clk);
    func3 = f; rs1 = a; rs2 = b; start = 1'b1;
    #1 if (!stall) stall_bad++;
    @(posedge clk);
    #1 start = 1'b0; rs1 = $urandom; rs2 = $urandom; func3 = 3'($urandom);
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (inject_cyc == lat) begin
        start = 1'b1; rs1 = $urandom; rs2 = $urandom; func3 = 3'($urandom);
      end else if (inject_cyc + 1 == lat) begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      if (busy && !stall) stall_bad++;
      if (valid) begin
        got = 1'b1;
        res = result;
        if (stall) stall_bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; func3 = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (valid !== 1'b0)   begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 0", result); end
    tests++; if (stall !== 1'b0)   begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  f[8]   = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] a[8]   = '{32'd7, MIN, MIN, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b[8]   = '{32'hFFFF_FFFD, MIN, MIN, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp[8] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF,
                            32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] res;
    int lat, bcnt, sbad;
    bit got;
    for (int i = 0; i < 8; i++) begin
      run_op(f[i], a[i], b[i], 0, res, lat, bcnt, sbad, got);
      tests++; if (!got || res !== exp[i]) begin fails++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, exp[i]); end
      tests++; if (lat != 34)  begin fails++; $display("FAIL directed_latency[%0d]: got %0d want 34", i, lat); end
      tests++; if (bcnt != 33) begin fails++; $display("FAIL directed_busy_cycles[%0d]: got %0d want 33", i, bcnt); end
      tests++; if (sbad != 0)  begin fails++; $display("FAIL directed_stall[%0d]: got %0d bad cycles want 0", i, sbad); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f[6]   = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] a[6]   = '{32'd5, 32'd5, 32'd5, 32'd5, MIN, MIN};
    logic [31:0] b[6]   = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp[6] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, MIN, 32'd0};
    logic [31:0] res;
    int lat, bcnt, sbad;
    bit got;
    for (int i = 0; i < 6; i++) begin
      run_op(f[i], a[i], b[i], 0, res, lat, bcnt, sbad, got);
      tests++; if (!got || res !== exp[i]) begin fails++; $display("FAIL special_result[%0d]: got %h want %h", i, res, exp[i]); end
      tests++; if (lat != 1)  begin fails++; $display("FAIL special_latency[%0d]: got %0d want 1", i, lat); end
      tests++; if (bcnt != 0) begin fails++; $display("FAIL special_busy[%0d]: got %0d busy cycles want 0", i, bcnt); end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] res;
    int lat, bcnt, sbad;
    bit got;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 10, res, lat, bcnt, sbad, got);
    tests++; if (!got || res !== 32'hFFFF_FFEB) begin fails++; $display("FAIL ignore_calc_result: got %h want ffffffeb", res); end
    tests++; if (lat != 34) begin fails++; $display("FAIL ignore_calc_latency: got %0d want 34", lat); end
    // Now sitting in the DONE cycle: a start here must not be taken
    start = 1'b1; func3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
    #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL done_stall: got %b want 0", stall); end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL done_start_busy: got %b want 0", busy); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL done_start_valid: got %b want 0", valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat, bcnt, sbad, vcnt;
    bit got;
    @(negedge clk);
    start = 1'b1; func3 = 3'd0; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL midreset_busy: got %b want 0", busy); end
    tests++; if (valid !== 1'b0)   begin fails++; $display("FAIL midreset_valid: got %b want 0", valid); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL midreset_result: got %h want 0", result); end
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    tests++; if (vcnt != 0) begin fails++; $display("FAIL midreset_no_valid: got %0d pulses want 0", vcnt); end
    run_op(3'd5, 32'd100, 32'd7, 0, res, lat, bcnt, sbad, got);
    tests++; if (!got || res !== 32'd14) begin fails++; $display("FAIL midreset_divu: got %h want 0000000e", res); end
    tests++; if (lat != 34) begin fails++; $display("FAIL midreset_divu_latency: got %0d want 34", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat, bcnt, sbad;
    bit got;
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res, lat, bcnt, sbad, got);
    tests++; if (!got || res !== 32'hFFFF_FFFE) begin fails++; $display("FAIL b2b_first: got %h want fffffffe", res); end
    run_op(3'd7, 32'd1000, 32'd33, 0, res, lat, bcnt, sbad, got);
    tests++; if (!got || res !== 32'd10) begin fails++; $display("FAIL b2b_second: got %h want 0000000a", res); end
    tests++; if (lat != 34) begin fails++; $display("FAIL b2b_second_latency: got %0d want 34", lat); end
    @(negedge clk);
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL b2b_valid_pulse_width: got %b want 0", valid); end
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b, res, exp;
    int lat, bcnt, sbad, exp_lat;
    bit got;
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exp = ref_model(f, a, b);
      exp_lat = ref_latency(f, a, b);
      run_op(f, a, b, 0, res, lat, bcnt, sbad, got);
      tests++;
      if (!got || res !== exp) begin
        fails++;
        $display("FAIL random_result[%0d] f=%0d a=%h b=%h: got %h want %h", i, f, a, b, res, exp);
      end
      tests++;
      if (lat != exp_lat || sbad != 0) begin
        fails++;
        $display("FAIL random_timing[%0d] f=%0d: latency %0d want %0d, stall errors %0d", i, f, lat, exp_lat, sbad);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_special();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
